// File: rtl/exp_pkg.sv
// rtl/exp_pkg.sv - shared state encoding and default sizes for the exponent sweep driver
package exp_pkg;

   localparam int N_WIDTH_DEF = 8;
   localparam int R_WIDTH_DEF = 16;
   localparam int TIMEOUT_DEF = 1023;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE    = 3'd0;
   localparam state_t S_ISSUE   = 3'd1;
   localparam state_t S_WAIT    = 3'd2;
   localparam state_t S_CHECK   = 3'd3;
   localparam state_t S_RELEASE = 3'd4;
   localparam state_t S_DONE    = 3'd5;
   localparam state_t S_ERROR   = 3'd6;

endpackage

// File: rtl/exp_result_capture.sv
// rtl/exp_result_capture.sv - first-done capture of one unit's result
// EXP_SWEEP_CYCLE_COUNT_EN adds a saturating request-latency counter.
module exp_result_capture
   import exp_pkg::*;
#(
   parameter int R_WIDTH = R_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               arm,
   input  logic               count,
   input  logic               latch,
   input  logic               done,
   input  logic [R_WIDTH-1:0] res,
   output logic               captured,
   output logic               captured_next,
   output logic [R_WIDTH-1:0] result,
   output logic [15:0]        cyc
);

   logic take;

   // Only the first done of a request is taken; later highs are ignored.
   assign take          = arm && done && !captured;
   assign captured_next = captured || take;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         captured <= 1'b0;
         result   <= '0;
      end else if (clear) begin
         captured <= 1'b0;
      end else if (take) begin
         captured <= 1'b1;
         result   <= res;
      end
   end

`ifdef EXP_SWEEP_CYCLE_COUNT_EN
   logic [15:0] cnt;

   // The issue cycle counts as 1; every wait cycle up to and including capture adds one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= 16'd0;
         cyc <= 16'd0;
      end else begin
         if (clear) begin
            cnt <= 16'd1;
         end else if (count && !captured && cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
         end
         if (latch) begin
            cyc <= cnt;
         end
      end
   end
`else
   logic unused_count;
   assign unused_count = &{1'b0, count, latch};
   assign cyc          = 16'd0;
`endif

endmodule

// File: rtl/exp_sweep_driver.sv
// rtl/exp_sweep_driver.sv - sweeps exponents 0..n_last through two exponent units and compares results
// EXP_SWEEP_CYCLE_COUNT_EN enables per-unit latency reporting on cyc_normal_o/cyc_opt_o.
module exp_sweep_driver
   import exp_pkg::*;
#(
   parameter int N_WIDTH = N_WIDTH_DEF,
   parameter int R_WIDTH = R_WIDTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [N_WIDTH-1:0] a_i,
   input  logic [N_WIDTH-1:0] n_last_i,
   output logic               go_o,
   output logic [N_WIDTH-1:0] a_o,
   output logic [N_WIDTH-1:0] n_o,
   input  logic [R_WIDTH-1:0] res_normal_i,
   input  logic [R_WIDTH-1:0] res_opt_i,
   input  logic               done_normal_i,
   input  logic               done_opt_i,
   output logic [R_WIDTH-1:0] result_o,
   output logic [N_WIDTH-1:0] n_cur_o,
   output logic               valid_o,
   output logic               mismatch_o,
   output logic               timeout_o,
   output logic               busy_o,
   output logic               finished_o,
   output logic [15:0]        cyc_normal_o,
   output logic [15:0]        cyc_opt_o
);

   localparam int TW = $clog2(TIMEOUT + 1);

   state_t             state;
   logic [N_WIDTH-1:0] n_last_q;
   logic [TW-1:0]      tmo_cnt;
   logic               tmo_hit;
   logic               dones_low;
   logic               in_issue;
   logic               in_wait;
   logic               in_check;
   logic               cap_normal;
   logic               cap_opt;
   logic               cap_normal_next;
   logic               cap_opt_next;
   logic [R_WIDTH-1:0] res_normal_q;
   logic [R_WIDTH-1:0] res_opt_q;

   assign in_issue  = (state == S_ISSUE);
   assign in_wait   = (state == S_WAIT);
   assign in_check  = (state == S_CHECK);
   assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
   assign dones_low = !done_normal_i && !done_opt_i;

   // Decoded from the state register so reset drops go_o without waiting for a clock.
   assign go_o   = in_issue || in_wait;
   assign busy_o = in_issue || in_wait || in_check || (state == S_RELEASE);

   exp_result_capture #(.R_WIDTH(R_WIDTH)) u_cap_normal (
      .clk           (clk),
      .rst           (rst),
      .clear         (in_issue),
      .arm           (in_wait),
      .count         (in_wait),
      .latch         (in_check),
      .done          (done_normal_i),
      .res           (res_normal_i),
      .captured      (cap_normal),
      .captured_next (cap_normal_next),
      .result        (res_normal_q),
      .cyc           (cyc_normal_o)
   );

   exp_result_capture #(.R_WIDTH(R_WIDTH)) u_cap_opt (
      .clk           (clk),
      .rst           (rst),
      .clear         (in_issue),
      .arm           (in_wait),
      .count         (in_wait),
      .latch         (in_check),
      .done          (done_opt_i),
      .res           (res_opt_i),
      .captured      (cap_opt),
      .captured_next (cap_opt_next),
      .result        (res_opt_q),
      .cyc           (cyc_opt_o)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         a_o        <= '0;
         n_o        <= '0;
         n_last_q   <= '0;
         tmo_cnt    <= '0;
         result_o   <= '0;
         n_cur_o    <= '0;
         valid_o    <= 1'b0;
         mismatch_o <= 1'b0;
         timeout_o  <= 1'b0;
         finished_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start_i) begin
                  a_o        <= a_i;
                  n_last_q   <= n_last_i;
                  n_o        <= '0;
                  mismatch_o <= 1'b0;
                  timeout_o  <= 1'b0;
                  finished_o <= 1'b0;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               tmo_cnt <= '0;
               state   <= S_WAIT;
            end
            S_WAIT: begin
               // Leave as soon as both results are in, including a same-cycle final capture.
               if (cap_normal_next && cap_opt_next) begin
                  state <= S_CHECK;
               end else if (tmo_hit) begin
                  timeout_o <= 1'b1;
                  state     <= S_ERROR;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_CHECK: begin
               result_o <= res_normal_q;
               n_cur_o  <= n_o;
               valid_o  <= 1'b1;
               if (res_normal_q != res_opt_q) begin
                  mismatch_o <= 1'b1;
               end
               tmo_cnt <= '0;
               state   <= S_RELEASE;
            end
            S_RELEASE: begin
               if (dones_low) begin
                  if (n_o == n_last_q) begin
                     finished_o <= 1'b1;
                     state      <= S_DONE;
                  end else begin
                     n_o   <= n_o + 1'b1;
                     state <= S_ISSUE;
                  end
               end else if (tmo_hit) begin
                  timeout_o <= 1'b1;
                  state     <= S_ERROR;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   logic unused_caps;
   assign unused_caps = &{1'b0, cap_normal, cap_opt};

endmodule
